jtpopeye_objdma: RTL and testbench

JTPOPEYE_OBJDMA -- requirements
Module: jtpopeye_objdma

---
 rtl/jtpopeye_pkg.sv | 26 ++
 rtl/jtpopeye_objdma_pack.sv | 54 +++++
 rtl/jtpopeye_objdma.sv | 179 +++++++++++++++++
 tb/tb_jtpopeye_objdma.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtpopeye_pkg.sv
// Shared definitions for the object-table DMA.
// Holds the DMA state encoding, default parameter values and a small
// helper that sizes counters so single-entry configurations still get
// a one-bit signal.
package jtpopeye_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQ     = 3'd1,
      ST_XFER    = 3'd2,
      ST_FLUSH   = 3'd3,
      ST_WAIT_VB = 3'd4
   } dma_state_t;

   localparam int OBJN_DEF  = 64;
   localparam int OBJB_DEF  = 4;
   localparam int AW_DEF    = 10;
   localparam int BASE_DEF  = 0;
   localparam int HGATE_DEF = 1;

   // Width of a counter that must hold 0..n-1 (never narrower than 1 bit).
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/jtpopeye_objdma_pack.sv
// Object record assembly.
// Collects the bytes returned by the source memory into one record and
// raises a one-cen write strobe once the last byte of an object lands.
// Ports:
//   clk, rst_n, cen  - clock, async active-low reset, clock enable
//   cap              - capture din this cen (an address was issued last cen)
//   cap_byte         - byte position of the data being captured
//   cap_obj          - object index the data belongs to
//   din              - byte from source memory
//   obj_we           - one-cen write strobe, record complete
//   obj_addr         - object index of the completed record
//   obj_data         - assembled record, byte k in bits [8k+7:8k]
module jtpopeye_objdma_pack
   import jtpopeye_pkg::*;
#(
   parameter int OBJN = OBJN_DEF,
   parameter int OBJB = OBJB_DEF
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cen,
   input  logic                     cap,
   input  logic [cnt_w(OBJB)-1:0]   cap_byte,
   input  logic [cnt_w(OBJN)-1:0]   cap_obj,
   input  logic [7:0]               din,
   output logic                     obj_we,
   output logic [cnt_w(OBJN)-1:0]   obj_addr,
   output logic [8*OBJB-1:0]        obj_data
);

   localparam int BW = cnt_w(OBJB);

   logic cap_last;
   assign cap_last = (cap_byte == BW'(OBJB - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         obj_we   <= 1'b0;
         obj_addr <= '0;
         obj_data <= '0;
      end else if (cen) begin
         // The strobe is registered together with the final byte so the
         // record is whole for the entire cen period the strobe is high.
         obj_we <= cap & cap_last;
         if (cap) begin
            for (int k = 0; k < OBJB; k++) begin
               if (cap_byte == BW'(k)) obj_data[8*k +: 8] <= din;
            end
            if (cap_last) obj_addr <= cap_obj;
         end
      end
   end

endmodule

// File: rtl/jtpopeye_objdma.sv
// Object table DMA.
// During vertical blanking this block requests the CPU bus, reads the
// object table byte by byte from source memory and writes whole object
// records into the object buffer. If VB ends before the table is done,
// the copy is abandoned and a sticky overrun flag is raised until the
// next VB rise.
// Ports:
//   clk, rst_n, cen - clock, async active-low reset, clock enable
//   VB              - vertical blanking
//   HBD_n           - active-low horizontal blanking window for DMA
//   busak_n         - CPU bus acknowledge (active low)
//   DD_DMA          - source data, valid one cen after its address
//   busrq_n         - CPU bus request (active low)
//   AD_DMA, dma_cs  - source address and select
//   obj_we, obj_addr, obj_data - object buffer write port
//   done            - one-cen pulse when the whole table has been copied
//   overrun         - sticky, VB ended before the table completed
//
// Handshake: an address is issued on a cen edge only when busak_n is low
// (and HBD_n is low if HGATE=1); the matching byte is taken on the next
// cen edge, regardless of whether the following address can be issued.
module jtpopeye_objdma
   import jtpopeye_pkg::*;
#(
   parameter int OBJN  = OBJN_DEF,
   parameter int OBJB  = OBJB_DEF,
   parameter int AW    = AW_DEF,
   parameter int BASE  = BASE_DEF,
   parameter int HGATE = HGATE_DEF
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cen,
   input  logic                     VB,
   input  logic                     HBD_n,
   input  logic                     busak_n,
   input  logic [7:0]               DD_DMA,
   output logic                     busrq_n,
   output logic [AW-1:0]            AD_DMA,
   output logic                     dma_cs,
   output logic                     obj_we,
   output logic [cnt_w(OBJN)-1:0]   obj_addr,
   output logic [8*OBJB-1:0]        obj_data,
   output logic                     done,
   output logic                     overrun
);

   localparam int OW = cnt_w(OBJN);
   localparam int BW = cnt_w(OBJB);
   localparam logic [AW-1:0] BASE_A = AW'(BASE);

   dma_state_t     state, state_nx;
   logic [OW-1:0]  obj_cnt, obj_nx, iss_obj, iss_obj_nx;
   logic [BW-1:0]  byte_cnt, byte_nx, iss_byte, iss_byte_nx;
   logic [AW-1:0]  ad_nx, addr_cur;
   logic           cs_nx, done_nx, ovr_nx;
   logic           vb_l, vb_rise, vb_fall;
   logic           issue_en, abort;
   logic           obj_end, tbl_end;

   assign vb_rise  = VB & ~vb_l;
   assign vb_fall  = ~VB & vb_l;
   assign issue_en = ~busak_n & ((HGATE == 0) | ~HBD_n);
   assign obj_end  = (byte_cnt == BW'(OBJB - 1));
   assign tbl_end  = obj_end & (obj_cnt == OW'(OBJN - 1));
   // Computed at AW bits so the sum wraps the same way the address bus does.
   assign addr_cur = BASE_A + AW'(obj_cnt) * AW'(OBJB) + AW'(byte_cnt);

   // Bus is requested for the whole copy, including paused stretches.
   assign busrq_n = ~((state == ST_REQ) | (state == ST_XFER) | (state == ST_FLUSH));

   always_comb begin
      state_nx    = state;
      obj_nx      = obj_cnt;
      byte_nx     = byte_cnt;
      iss_obj_nx  = iss_obj;
      iss_byte_nx = iss_byte;
      ad_nx       = AD_DMA;
      cs_nx       = 1'b0;
      done_nx     = 1'b0;
      ovr_nx      = overrun;
      abort       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (vb_rise) begin
               state_nx = ST_REQ;
               obj_nx   = '0;
               byte_nx  = '0;
               ovr_nx   = 1'b0;
            end
         end
         ST_REQ: begin
            if (vb_fall)       abort    = 1'b1;
            else if (!busak_n) state_nx = ST_XFER;
         end
         ST_XFER: begin
            if (vb_fall) begin
               abort = 1'b1;
            end else if (issue_en) begin
               ad_nx       = addr_cur;
               cs_nx       = 1'b1;
               iss_obj_nx  = obj_cnt;
               iss_byte_nx = byte_cnt;
               if (tbl_end) begin
                  state_nx = ST_FLUSH;
                  obj_nx   = '0;
                  byte_nx  = '0;
               end else if (obj_end) begin
                  obj_nx  = obj_cnt + OW'(1);
                  byte_nx = '0;
               end else begin
                  byte_nx = byte_cnt + BW'(1);
               end
            end
         end
         ST_FLUSH: begin
            // The final byte is captured by the pack stage on this edge.
            if (vb_fall) begin
               abort = 1'b1;
            end else begin
               done_nx  = 1'b1;
               state_nx = ST_WAIT_VB;
            end
         end
         ST_WAIT_VB: begin
            if (!VB) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
      if (abort) begin
         state_nx = ST_IDLE;
         ovr_nx   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         vb_l     <= 1'b0;
         obj_cnt  <= '0;
         byte_cnt <= '0;
         iss_obj  <= '0;
         iss_byte <= '0;
         AD_DMA   <= BASE_A;
         dma_cs   <= 1'b0;
         done     <= 1'b0;
         overrun  <= 1'b0;
      end else if (cen) begin
         state    <= state_nx;
         vb_l     <= VB;
         obj_cnt  <= obj_nx;
         byte_cnt <= byte_nx;
         iss_obj  <= iss_obj_nx;
         iss_byte <= iss_byte_nx;
         AD_DMA   <= ad_nx;
         dma_cs   <= cs_nx;
         done     <= done_nx;
         overrun  <= ovr_nx;
      end
   end

   // An abort drops the in-flight byte so no partial object is written.
   jtpopeye_objdma_pack #(
      .OBJN (OBJN),
      .OBJB (OBJB)
   ) u_pack (
      .clk      (clk),
      .rst_n    (rst_n),
      .cen      (cen),
      .cap      (dma_cs & ~abort),
      .cap_byte (iss_byte),
      .cap_obj  (iss_obj),
      .din      (DD_DMA),
      .obj_we   (obj_we),
      .obj_addr (obj_addr),
      .obj_data (obj_data)
   );

endmodule

// File: tb/tb_jtpopeye_objdma.sv
module tb_jtpopeye_objdma;

   localparam int OBJN = 4;
   localparam int OBJB = 2;
   localparam int AW   = 10;
   localparam int BASE = 32'h100;

   // clock / reset
   logic clk = 1'b0;
   logic cen = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   always @(negedge clk) cen = ~cen;

   // ungated instance (HGATE=0)
   logic        vb = 1'b0, hbd_n = 1'b1, ak_rel = 1'b0;
   logic        ak_d1 = 1'b1, ak_d2 = 1'b1;
   logic        busak_n, busrq_n, dma_cs, obj_we, done, overrun;
   logic [7:0]  dd;
   logic [AW-1:0] ad;
   logic [1:0]  obj_addr;
   logic [15:0] obj_data;
   assign busak_n = ak_d2 | ak_rel;
   assign dd      = ad[7:0];

   // gated instance (HGATE=1)
   logic        vb_g = 1'b0, hbd_g = 1'b1;
   logic        akg_d1 = 1'b1, akg_d2 = 1'b1;
   logic        busrq_g, dma_cs_g, obj_we_g, done_g, overrun_g;
   logic [7:0]  dd_g;
   logic [AW-1:0] ad_g;
   logic [1:0]  obj_addr_g;
   logic [15:0] obj_data_g;
   assign dd_g = ad_g[7:0];

   jtpopeye_objdma #(.OBJN(OBJN), .OBJB(OBJB), .AW(AW), .BASE(BASE), .HGATE(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .VB(vb), .HBD_n(hbd_n), .busak_n(busak_n),
      .DD_DMA(dd), .busrq_n(busrq_n), .AD_DMA(ad), .dma_cs(dma_cs), .obj_we(obj_we),
      .obj_addr(obj_addr), .obj_data(obj_data), .done(done), .overrun(overrun)
   );

   jtpopeye_objdma #(.OBJN(OBJN), .OBJB(OBJB), .AW(AW), .BASE(BASE), .HGATE(1)) u_gate (
      .clk(clk), .rst_n(rst_n), .cen(cen), .VB(vb_g), .HBD_n(hbd_g), .busak_n(akg_d2),
      .DD_DMA(dd_g), .busrq_n(busrq_g), .AD_DMA(ad_g), .dma_cs(dma_cs_g), .obj_we(obj_we_g),
      .obj_addr(obj_addr_g), .obj_data(obj_data_g), .done(done_g), .overrun(overrun_g)
   );

   // bus acknowledge follows request two cen later
   always @(posedge clk) begin
      if (cen) begin
         ak_d1  <= busrq_n;
         ak_d2  <= ak_d1;
         akg_d1 <= busrq_g;
         akg_d2 <= akg_d1;
      end
   end

   // scoreboard
   int chk_cnt = 0, pass_cnt = 0;
   int done_cnt = 0, done_g_cnt = 0;
   logic [17:0] got_q[$], got_g_q[$], exp_q[$];

   always @(posedge clk) begin
      if (cen && rst_n) begin
         if (obj_we)   got_q.push_back({obj_addr, obj_data});
         if (done)     done_cnt++;
         if (obj_we_g) got_g_q.push_back({obj_addr_g, obj_data_g});
         if (done_g)   done_g_cnt++;
      end
   end

   // driver tasks
   task automatic step();
      do @(posedge clk); while (!cen);
      #1;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic load_exp();
      exp_q.delete();
      exp_q.push_back({2'd0, 16'h0100});
      exp_q.push_back({2'd1, 16'h0302});
      exp_q.push_back({2'd2, 16'h0504});
      exp_q.push_back({2'd3, 16'h0706});
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #23;
      chk_cnt++; if (busrq_n !== 1'b1) $display("FAIL reset_busrq_n: got %b want 1", busrq_n); else pass_cnt++;
      chk_cnt++; if (dma_cs !== 1'b0) $display("FAIL reset_dma_cs: got %b want 0", dma_cs); else pass_cnt++;
      chk_cnt++; if (obj_we !== 1'b0) $display("FAIL reset_obj_we: got %b want 0", obj_we); else pass_cnt++;
      chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
      chk_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else pass_cnt++;
      chk_cnt++; if (ad !== 10'h100) $display("FAIL reset_ad: got %h want 100", ad); else pass_cnt++;
      chk_cnt++; if (obj_addr !== 2'd0) $display("FAIL reset_obj_addr: got %0d want 0", obj_addr); else pass_cnt++;
      chk_cnt++; if (obj_data !== 16'h0) $display("FAIL reset_obj_data: got %h want 0000", obj_data); else pass_cnt++;
      chk_cnt++; if (busrq_g !== 1'b1) $display("FAIL reset_busrq_g: got %b want 1", busrq_g); else pass_cnt++;
      step();
      rst_n = 1'b1;
      steps(4);
   endtask

   task automatic test_basic();
      int cycles;
      logic [17:0] g;
      got_q.delete();
      done_cnt = 0;
      cycles = 0;
      vb = 1'b1;
      do begin step(); cycles++; end while (!done && cycles < 100);
      chk_cnt++; if (cycles != 13) $display("FAIL basic_latency: got %0d cen want 13", cycles); else pass_cnt++;
      step();
      chk_cnt++; if (got_q.size() != 4) $display("FAIL basic_count: got %0d writes want 4", got_q.size()); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         g = (i < got_q.size()) ? got_q[i] : 18'h3ffff;
         chk_cnt++; if (g !== exp_q[i]) $display("FAIL basic_obj%0d: got %h want %h", i, g, exp_q[i]); else pass_cnt++;
      end
      chk_cnt++; if (done_cnt != 1) $display("FAIL basic_done: got %0d pulses want 1", done_cnt); else pass_cnt++;
      chk_cnt++; if (busrq_n !== 1'b1) $display("FAIL basic_busrq_after: got %b want 1", busrq_n); else pass_cnt++;
      chk_cnt++; if (overrun !== 1'b0) $display("FAIL basic_overrun: got %b want 0", overrun); else pass_cnt++;
   endtask

   task automatic test_hold_vb();
      int low_seen, cycles;
      low_seen = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (busrq_n === 1'b0) low_seen++;
      end
      chk_cnt++; if (low_seen != 0) $display("FAIL hold_vb_busrq: got %0d low cen want 0", low_seen); else pass_cnt++;
      chk_cnt++; if (done_cnt != 1) $display("FAIL hold_vb_done: got %0d pulses want 1", done_cnt); else pass_cnt++;
      vb = 1'b0;
      steps(4);
      vb = 1'b1;
      step();
      chk_cnt++; if (busrq_n !== 1'b0) $display("FAIL hold_vb_rerequest: got %b want 0", busrq_n); else pass_cnt++;
      cycles = 0;
      do begin step(); cycles++; end while (!done && cycles < 100);
      chk_cnt++; if (cycles != 12) $display("FAIL hold_vb_second_copy: got %0d cen want 12", cycles); else pass_cnt++;
      step();
      vb = 1'b0;
      steps(4);
   endtask

   task automatic test_overrun();
      int cycles;
      got_q.delete();
      cycles = 0;
      vb = 1'b1;
      do begin step(); cycles++; end while (!(dma_cs && ad == 10'h102) && cycles < 100);
      chk_cnt++; if (cycles != 7) $display("FAIL ovr_third_addr: got %0d cen want 7", cycles); else pass_cnt++;
      vb = 1'b0;
      step();
      chk_cnt++; if (busrq_n !== 1'b1) $display("FAIL ovr_busrq: got %b want 1", busrq_n); else pass_cnt++;
      chk_cnt++; if (dma_cs !== 1'b0) $display("FAIL ovr_dma_cs: got %b want 0", dma_cs); else pass_cnt++;
      chk_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", overrun); else pass_cnt++;
      steps(4);
      chk_cnt++; if (got_q.size() != 1) $display("FAIL ovr_writes: got %0d want 1", got_q.size()); else pass_cnt++;
      chk_cnt++; if (got_q.size() > 0 && got_q[0] !== exp_q[0]) $display("FAIL ovr_obj0: got %h want %h", got_q[0], exp_q[0]); else pass_cnt++;
      chk_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", overrun); else pass_cnt++;
      vb = 1'b1;
      step();
      chk_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b want 0", overrun); else pass_cnt++;
      cycles = 0;
      do begin step(); cycles++; end while (!done && cycles < 100);
      chk_cnt++; if (done !== 1'b1) $display("FAIL ovr_recover_done: got %b want 1", done); else pass_cnt++;
      step();
      vb = 1'b0;
      steps(4);
   endtask

   task automatic test_pause();
      int cycles;
      logic [17:0] g;
      got_q.delete();
      cycles = 0;
      vb = 1'b1;
      do begin step(); cycles++; end while (!(dma_cs && ad == 10'h104) && cycles < 100);
      chk_cnt++; if (cycles != 9) $display("FAIL pause_reach: got %0d cen want 9", cycles); else pass_cnt++;
      ak_rel = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(); cycles++;
         chk_cnt++;
         if ({busrq_n, dma_cs, ad} !== {1'b0, 1'b0, 10'h104})
            $display("FAIL pause_hold%0d: got rq=%b cs=%b ad=%h want rq=0 cs=0 ad=104", i, busrq_n, dma_cs, ad);
         else pass_cnt++;
      end
      ak_rel = 1'b0;
      do begin step(); cycles++; end while (!done && cycles < 100);
      chk_cnt++; if (cycles != 18) $display("FAIL pause_latency: got %0d cen want 18", cycles); else pass_cnt++;
      step();
      for (int i = 0; i < 4; i++) begin
         g = (i < got_q.size()) ? got_q[i] : 18'h3ffff;
         chk_cnt++; if (g !== exp_q[i]) $display("FAIL pause_obj%0d: got %h want %h", i, g, exp_q[i]); else pass_cnt++;
      end
      vb = 1'b0;
      steps(4);
   endtask

   task automatic test_reset_mid();
      int cycles;
      logic [17:0] g;
      cycles = 0;
      vb = 1'b1;
      do begin step(); cycles++; end while (!(dma_cs && ad == 10'h103) && cycles < 100);
      chk_cnt++; if (cycles != 8) $display("FAIL rstmid_reach: got %0d cen want 8", cycles); else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      chk_cnt++;
      if ({busrq_n, dma_cs, obj_we, done, overrun, ad, obj_addr, obj_data} !==
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h100, 2'd0, 16'h0000})
         $display("FAIL rstmid_outputs: got rq=%b cs=%b we=%b dn=%b ov=%b ad=%h oa=%0d od=%h want 1 0 0 0 0 100 0 0000",
                  busrq_n, dma_cs, obj_we, done, overrun, ad, obj_addr, obj_data);
      else pass_cnt++;
      #2 rst_n = 1'b1;
      vb = 1'b0;
      steps(4);
      got_q.delete();
      cycles = 0;
      vb = 1'b1;
      do begin step(); cycles++; end while (!dma_cs && cycles < 100);
      chk_cnt++; if (ad !== 10'h100) $display("FAIL rstmid_restart_ad: got %h want 100", ad); else pass_cnt++;
      chk_cnt++; if (cycles != 5) $display("FAIL rstmid_restart_lat: got %0d cen want 5", cycles); else pass_cnt++;
      do begin step(); cycles++; end while (!done && cycles < 100);
      step();
      for (int i = 0; i < 4; i++) begin
         g = (i < got_q.size()) ? got_q[i] : 18'h3ffff;
         chk_cnt++; if (g !== exp_q[i]) $display("FAIL rstmid_obj%0d: got %h want %h", i, g, exp_q[i]); else pass_cnt++;
      end
      vb = 1'b0;
      steps(4);
   endtask

   task automatic test_hgate();
      int n, cs_cnt, bad;
      logic hbd_prev;
      logic [17:0] g;
      got_g_q.delete();
      done_g_cnt = 0;
      n = 0; cs_cnt = 0; bad = 0;
      vb_g = 1'b1;
      do begin
         hbd_g = ((n / 8) % 2) != 0;
         hbd_prev = hbd_g;
         step();
         n++;
         if (dma_cs_g) begin
            cs_cnt++;
            if (hbd_prev) bad++;
         end
      end while (!done_g && n < 400);
      chk_cnt++; if (n != 21) $display("FAIL hgate_latency: got %0d cen want 21", n); else pass_cnt++;
      chk_cnt++; if (bad != 0) $display("FAIL hgate_cs_outside: got %0d want 0", bad); else pass_cnt++;
      chk_cnt++; if (cs_cnt != 8) $display("FAIL hgate_cs_count: got %0d want 8", cs_cnt); else pass_cnt++;
      step();
      for (int i = 0; i < 4; i++) begin
         g = (i < got_g_q.size()) ? got_g_q[i] : 18'h3ffff;
         chk_cnt++; if (g !== exp_q[i]) $display("FAIL hgate_obj%0d: got %h want %h", i, g, exp_q[i]); else pass_cnt++;
      end
      chk_cnt++; if (done_g_cnt != 1) $display("FAIL hgate_done: got %0d want 1", done_g_cnt); else pass_cnt++;
      chk_cnt++; if (busrq_g !== 1'b1) $display("FAIL hgate_busrq_after: got %b want 1", busrq_g); else pass_cnt++;
      vb_g = 1'b0;
      steps(4);
   endtask

   initial begin
      load_exp();
      test_reset();
      test_basic();
      test_hold_vb();
      test_overrun();
      test_pause();
      test_reset_mid();
      test_hgate();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
